// File: rtl/spi_master.sv
// rtl/spi_master.sv - mode-0 SPI master, 8-bit MSB-first frames, sclk = clk/2
module spi_master (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       wr,
  input  logic       rd,
  input  logic       cs,
  output logic [7:0] out_data,
  output logic       mosi,
  input  logic       miso,
  output logic       sclk
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t     state_q, state_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] rx_buf_q, rx_buf_d;
  logic [7:0] out_q, out_d;
  logic [3:0] cnt_q, cnt_d;
  logic       sclk_q, sclk_d;
  logic       wr_ok, rd_ok;

  assign wr_ok = wr & ~cs;
  assign rd_ok = rd & ~cs;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tx_q     <= 8'h00;
      rx_q     <= 8'h00;
      rx_buf_q <= 8'h00;
      out_q    <= 8'h00;
      cnt_q    <= 4'd0;
      sclk_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      rx_buf_q <= rx_buf_d;
      out_q    <= out_d;
      cnt_q    <= cnt_d;
      sclk_q   <= sclk_d;
    end
  end

  // Even edge counts raise sclk and sample miso; odd counts lower sclk and advance mosi.
  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    rx_buf_d = rx_buf_q;
    out_d    = out_q;
    cnt_d    = cnt_q;
    sclk_d   = sclk_q;

    if (rd_ok) begin
      out_d = rx_buf_q;
    end

    case (state_q)
      IDLE: begin
        sclk_d = 1'b0;
        if (wr_ok) begin
          tx_d    = in_data;
          rx_d    = 8'h00;
          cnt_d   = 4'd0;
          state_d = XFER;
        end
      end
      XFER: begin
        cnt_d = cnt_q + 4'd1;
        if (!cnt_q[0]) begin
          sclk_d = 1'b1;
          rx_d   = {rx_q[6:0], miso};
        end else begin
          sclk_d = 1'b0;
          if (cnt_q == 4'd15) begin
            rx_buf_d = rx_q;
            state_d  = IDLE;
          end else begin
            tx_d = {tx_q[6:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mosi     = (state_q == XFER) & tx_q[7];
  assign sclk     = sclk_q;
  assign out_data = out_q;

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - directed self-checking bench for spi_master
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       wr, rd, cs;
  logic [7:0] out_data;
  logic       mosi, miso, sclk;
  logic       loop_en, miso_drv;

  int tests = 0;
  int fails = 0;

  assign miso = loop_en ? mosi : miso_drv;

  always #5 clk = ~clk;

  spi_master dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_data (in_data),
    .wr      (wr),
    .rd      (rd),
    .cs      (cs),
    .out_data(out_data),
    .mosi    (mosi),
    .miso    (miso),
    .sclk    (sclk)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic start_write(input logic [7:0] b);
    in_data = b;
    cs = 1'b0;
    wr = 1'b1;
    @(posedge clk);
    #1;
    wr = 1'b0;
  endtask

  task automatic do_read(input logic sel_n);
    cs = sel_n;
    rd = 1'b1;
    @(posedge clk);
    #1;
    rd = 1'b0;
    cs = 1'b0;
  endtask

  // Samples edges N..N+16 of a frame; optional write/read strobes land on edge N+inj_*_k.
  task automatic capture(input int inj_wr_k, input int inj_rd_k,
                         output logic [7:0] bits, output int pulses, output int bad);
    logic prev;
    prev = 1'b0;
    bits = 8'h00;
    pulses = 0;
    bad = 0;
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      if (sclk && !prev) begin
        pulses++;
        bits = {bits[6:0], mosi};
      end
      if (sclk !== ((k % 2 == 1) && (k < 16))) bad++;
      if (k == 16 && mosi !== 1'b0) bad++;
      prev = sclk;
      wr = 1'b0;
      rd = 1'b0;
      if (k + 1 == inj_wr_k) begin
        in_data = 8'hFF;
        wr = 1'b1;
      end
      if (k + 1 == inj_rd_k) rd = 1'b1;
    end
    wr = 1'b0;
    rd = 1'b0;
  endtask

  task automatic idle_watch(input int n, output int active);
    active = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (sclk !== 1'b0 || mosi !== 1'b0) active++;
    end
  endtask

  task automatic test_reset;
    int act;
    rst_n = 1'b0; wr = 1'b1; cs = 1'b0; rd = 1'b0; in_data = 8'hFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++; if (sclk !== 1'b0) begin fails++; $display("FAIL reset_sclk got %b want 0", sclk); end
    tests++; if (mosi !== 1'b0) begin fails++; $display("FAIL reset_mosi got %b want 0", mosi); end
    tests++; if (out_data !== 8'h00) begin fails++; $display("FAIL reset_out got %h want 00", out_data); end
    wr = 1'b0;
    rst_n = 1'b1;
    idle_watch(6, act);
    tests++; if (act !== 0) begin fails++; $display("FAIL reset_no_xfer got %0d active cycles want 0", act); end
  endtask

  task automatic test_single_write;
    logic [7:0] bits; int p, bad;
    loop_en = 1'b0; miso_drv = 1'b0;
    start_write(8'hAA);
    capture(-1, -1, bits, p, bad);
    tests++; if (bits !== 8'hAA) begin fails++; $display("FAIL single_bits got %h want aa", bits); end
    tests++; if (p !== 8) begin fails++; $display("FAIL single_pulses got %0d want 8", p); end
    tests++; if (bad !== 0) begin fails++; $display("FAIL single_shape got %0d bad samples want 0", bad); end
    do_read(1'b0);
    tests++; if (out_data !== 8'h00) begin fails++; $display("FAIL single_read got %h want 00", out_data); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] vals [3];
    logic [7:0] bits; int p, bad;
    vals[0] = 8'h91; vals[1] = 8'hF0; vals[2] = 8'h12;
    for (int i = 0; i < 3; i++) begin
      start_write(vals[i]);
      capture(-1, -1, bits, p, bad);
      tests++; if (bits !== vals[i]) begin fails++; $display("FAIL b2b_bits[%0d] got %h want %h", i, bits, vals[i]); end
      tests++; if (p !== 8 || bad !== 0) begin fails++; $display("FAIL b2b_pulses[%0d] got %0d pulses %0d bad want 8 0", i, p, bad); end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_loopback;
    logic [7:0] bits; int p, bad;
    loop_en = 1'b1;
    start_write(8'h5A);
    capture(-1, -1, bits, p, bad);
    tests++; if (bits !== 8'h5A) begin fails++; $display("FAIL loop_bits got %h want 5a", bits); end
    do_read(1'b0);
    tests++; if (out_data !== 8'h5A) begin fails++; $display("FAIL loop_read1 got %h want 5a", out_data); end
    start_write(8'hC3);
    capture(-1, -1, bits, p, bad);
    do_read(1'b0);
    tests++; if (out_data !== 8'hC3) begin fails++; $display("FAIL loop_read2 got %h want c3", out_data); end
    start_write(8'h3C);
    capture(-1, -1, bits, p, bad);
    do_read(1'b1);
    tests++; if (out_data !== 8'hC3) begin fails++; $display("FAIL loop_read_cs_hi got %h want c3", out_data); end
    do_read(1'b0);
    tests++; if (out_data !== 8'h3C) begin fails++; $display("FAIL loop_read3 got %h want 3c", out_data); end
    loop_en = 1'b0;
  endtask

  task automatic test_ignore;
    logic [7:0] bits; int p, bad, act;
    miso_drv = 1'b0;
    in_data = 8'hFF; cs = 1'b1; wr = 1'b1;
    @(posedge clk);
    #1;
    wr = 1'b0; cs = 1'b0;
    idle_watch(18, act);
    tests++; if (act !== 0) begin fails++; $display("FAIL ign_cs_high got %0d active cycles want 0", act); end

    start_write(8'hA5);
    capture(5, -1, bits, p, bad);
    tests++; if (bits !== 8'hA5 || p !== 8 || bad !== 0) begin
      fails++; $display("FAIL ign_mid_write got %h/%0d/%0d want a5/8/0", bits, p, bad);
    end
    idle_watch(18, act);
    tests++; if (act !== 0) begin fails++; $display("FAIL ign_no_second got %0d active cycles want 0", act); end

    miso_drv = 1'b1;
    start_write(8'h81);
    capture(16, 16, bits, p, bad);
    tests++; if (bits !== 8'h81 || p !== 8) begin fails++; $display("FAIL ign_n16_frame got %h/%0d want 81/8", bits, p); end
    tests++; if (out_data !== 8'h00) begin fails++; $display("FAIL read_at_n16 got %h want 00", out_data); end
    start_write(8'h66);
    capture(-1, -1, bits, p, bad);
    tests++; if (bits !== 8'h66 || p !== 8 || bad !== 0) begin
      fails++; $display("FAIL write_at_n17 got %h/%0d/%0d want 66/8/0", bits, p, bad);
    end
    do_read(1'b0);
    tests++; if (out_data !== 8'hFF) begin fails++; $display("FAIL ign_read_ff got %h want ff", out_data); end
  endtask

  task automatic test_abort;
    int act;
    miso_drv = 1'b1;
    do_read(1'b0);
    start_write(8'hF0);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    tests++; if (sclk !== 1'b0) begin fails++; $display("FAIL abort_sclk got %b want 0", sclk); end
    tests++; if (mosi !== 1'b0) begin fails++; $display("FAIL abort_mosi got %b want 0", mosi); end
    rst_n = 1'b1;
    do_read(1'b0);
    tests++; if (out_data !== 8'h00) begin fails++; $display("FAIL abort_read got %h want 00", out_data); end
    idle_watch(18, act);
    tests++; if (act !== 0) begin fails++; $display("FAIL abort_idle got %0d active cycles want 0", act); end
  endtask

  initial begin
    rst_n = 1'b0; in_data = 8'h00; wr = 1'b0; rd = 1'b0; cs = 1'b1;
    loop_en = 1'b0; miso_drv = 1'b0;
    test_reset();
    test_single_write();
    test_back_to_back();
    test_loopback();
    test_ignore();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
